// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared constants and types for the pixel-processing line readers.
//   PIX_SIZE   : pixel word width (matches the line-buffer RAM word width)
//   LINE_DEPTH : number of line-buffer RAM entries
//   LINE_COUNT : pixels emitted per line
//   line_state_e : scanline reader control state encoding
// ---------------------------------------------------------------------------
package ppu_pkg;

    localparam int PIX_SIZE   = 8;
    localparam int LINE_DEPTH = 256;
    localparam int LINE_COUNT = 160;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } line_state_e;

endpackage

// File: rtl/skid_fifo_2.sv
// ---------------------------------------------------------------------------
// skid_fifo_2
// Two-entry FIFO that absorbs the one-cycle RAM read latency against
// downstream backpressure.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push_i    : write din_i this cycle (ignored when full and not popping)
//   din_i     : write data
//   pop_i     : remove the head entry this cycle (ignored when empty)
//   head_o    : current head entry (zero after reset)
//   count_o   : number of stored entries, 0..2
// ---------------------------------------------------------------------------
module skid_fifo_2
    import ppu_pkg::*;
#(
    parameter int SIZE = PIX_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic [SIZE-1:0] din_i,
    input  logic            pop_i,
    output logic [SIZE-1:0] head_o,
    output logic [1:0]      count_o
);

    logic [SIZE-1:0] mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q;
    logic            pop_s;
    logic            push_s;

    // Qualify requests so a misbehaving caller can never corrupt the count.
    always_comb begin
        pop_s  = pop_i && (count_q != 2'd0);
        push_s = push_i && ((count_q != 2'd2) || pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/scanline_reader.sv
// ---------------------------------------------------------------------------
// scanline_reader
// Reads COUNT consecutive words of an external line-buffer RAM, starting at
// base_addr (wrapping modulo DEPTH), and streams them out as pixels with a
// valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle line request (accepted only when idle)
//   base_addr  : first RAM address, latched with an accepted start
//   raddr      : RAM read address; read_data returns one cycle later
//   read_data  : RAM read data
//   pix_data   : pixel output, pix_valid qualifies, pix_ready accepts
//   pix_last   : marks the COUNT-th pixel of the line
//   busy       : line in progress
//   done       : one-cycle pulse after the last transfer
// ---------------------------------------------------------------------------
module scanline_reader
    import ppu_pkg::*;
#(
    parameter  int SIZE  = PIX_SIZE,
    parameter  int DEPTH = LINE_DEPTH,
    parameter  int COUNT = LINE_COUNT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    output logic [AW-1:0]   raddr,
    input  logic [SIZE-1:0] read_data,
    output logic [SIZE-1:0] pix_data,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic            pix_last,
    output logic            busy,
    output logic            done
);

    localparam int            CW       = $clog2(COUNT + 1);
    localparam logic [CW-1:0] COUNT_C  = CW'(COUNT);
    localparam logic [CW-1:0] LAST_C   = CW'(COUNT - 1);
    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);

    line_state_e   state_q;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] popped_q, popped_d;
    logic          inflight_q;
    logic          busy_q;
    logic          done_q;

    logic [1:0]    fifo_count_s;
    logic [2:0]    occ_s;
    logic          pop_s;
    logic          issue_s;
    logic          head_last_s;

    // Issue decision: keep FIFO entries plus the read in flight within two
    // after this cycle's pop, so a returning word always has a slot.
    always_comb begin
        pop_s       = (fifo_count_s != 2'd0) && pix_ready;
        occ_s       = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s     = (state_q == ST_RUN) && (issued_q < COUNT_C) && (occ_s < 3'd2);
        head_last_s = (popped_q == LAST_C);
        if (raddr_q == ADDR_MAX) begin
            raddr_d = '0;
        end else begin
            raddr_d = raddr_q + {{(AW-1){1'b0}}, 1'b1};
        end
        issued_d = issued_q + {{(CW-1){1'b0}}, 1'b1};
        popped_d = popped_q + {{(CW-1){1'b0}}, 1'b1};
    end

    // Line control FSM with its address/counter datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            raddr_q    <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    inflight_q <= 1'b0;
                    done_q     <= 1'b0;
                    if (start) begin
                        state_q  <= ST_RUN;
                        raddr_q  <= base_addr;
                        issued_q <= '0;
                        popped_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    inflight_q <= issue_s;
                    if (issue_s) begin
                        raddr_q  <= raddr_d;
                        issued_q <= issued_d;
                    end
                    if (pop_s) begin
                        if (head_last_s) begin
                            state_q  <= ST_DONE;
                            popped_q <= '0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            popped_q <= popped_d;
                        end
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    inflight_q <= 1'b0;
                    done_q     <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    inflight_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    // Each issued read lands in the FIFO the cycle after its address.
    skid_fifo_2 #(
        .SIZE (SIZE)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   (read_data),
        .pop_i   (pop_s),
        .head_o  (pix_data),
        .count_o (fifo_count_s)
    );

    assign raddr     = raddr_q;
    assign pix_valid = (fifo_count_s != 2'd0);
    assign pix_last  = pix_valid && head_last_s;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_scanline_reader.sv
// ---------------------------------------------------------------------------
// tb_scanline_reader
// Three readers (COUNT = 4, 8, 1) share a behavioural RAM model; each line's
// expected pixel stream is RAM[(base + k) mod 256] for k = 0..COUNT-1.
// ---------------------------------------------------------------------------
module tb_scanline_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start     [3];
    logic [7:0] base_addr [3];
    logic [7:0] raddr     [3];
    logic [7:0] read_data [3];
    logic [7:0] pix_data  [3];
    logic       pix_valid [3];
    logic       pix_ready [3];
    logic       pix_last  [3];
    logic       busy      [3];
    logic       done      [3];

    logic [7:0] ram [256];
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Synchronous-read RAM ports, one per reader.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) read_data[i] <= ram[raddr[i]];
    end

    scanline_reader #(.SIZE(8), .DEPTH(256), .COUNT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start[0]), .base_addr(base_addr[0]),
        .raddr(raddr[0]), .read_data(read_data[0]), .pix_data(pix_data[0]),
        .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]), .pix_last(pix_last[0]),
        .busy(busy[0]), .done(done[0]));

    scanline_reader #(.SIZE(8), .DEPTH(256), .COUNT(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start[1]), .base_addr(base_addr[1]),
        .raddr(raddr[1]), .read_data(read_data[1]), .pix_data(pix_data[1]),
        .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]), .pix_last(pix_last[1]),
        .busy(busy[1]), .done(done[1]));

    scanline_reader #(.SIZE(8), .DEPTH(256), .COUNT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[2]), .base_addr(base_addr[2]),
        .raddr(raddr[2]), .read_data(read_data[2]), .pix_data(pix_data[2]),
        .pix_valid(pix_valid[2]), .pix_ready(pix_ready[2]), .pix_last(pix_last[2]),
        .busy(busy[2]), .done(done[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // One line on reader d: start in cycle 0, observe at each falling edge.
    task automatic run_line(input int d, input int base, input int cnt,
                            input bit rnd, input bit timing, input bit inj);
        int         npix;
        bit         got_done;
        bit         stalled;
        bit         rdy;
        logic [7:0] held;
        npix     = 0;
        got_done = 1'b0;
        stalled  = 1'b0;
        held     = 8'h00;
        start[d]     = 1'b1;
        base_addr[d] = 8'(base);
        pix_ready[d] = 1'b0;
        for (int c = 1; c <= 400 && !got_done; c++) begin
            @(negedge clk);
            start[d] = 1'b0;
            if (c == 1) begin
                check("raddr_first", 32'(raddr[d]), 32'(base));
                check("busy_run", 32'(busy[d]), 32'd1);
            end
            if (timing && c <= cnt) check("raddr_seq", 32'(raddr[d]), 32'((base + c - 1) % 256));
            check("busy_done_excl", 32'(busy[d] & done[d]), 32'd0);
            if (stalled) begin
                check("hold_valid", 32'(pix_valid[d]), 32'd1);
                check("hold_data", 32'(pix_data[d]), 32'(held));
            end
            rdy = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            pix_ready[d] = rdy;
            stalled = pix_valid[d] && !rdy;
            held    = pix_data[d];
            if (pix_valid[d] && rdy) begin
                check("pix_data", 32'(pix_data[d]), 32'(ram[8'((base + npix) % 256)]));
                check("pix_last", 32'(pix_last[d]), 32'(npix == cnt - 1));
                if (timing) check("xfer_cycle", 32'(c), 32'(npix + 3));
                npix++;
            end
            if (done[d]) begin
                got_done = 1'b1;
                check("pix_count", 32'(npix), 32'(cnt));
                check("done_valid_low", 32'(pix_valid[d]), 32'd0);
                if (timing) check("done_cycle", 32'(c), 32'(cnt + 3));
            end
            if (inj && c == 4) begin
                start[d]     = 1'b1;
                base_addr[d] = 8'd99;
            end
        end
        check("line_done_seen", 32'(got_done), 32'd1);
        pix_ready[d] = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy[d]), 32'd0);
        check("idle_done", 32'(done[d]), 32'd0);
        check("idle_valid", 32'(pix_valid[d]), 32'd0);
    endtask

    initial begin
        int npix;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start[d]     = 1'b0;
            base_addr[d] = 8'h00;
            pix_ready[d] = 1'b0;
        end
        for (int a = 0; a < 256; a++) ram[a] = 8'($urandom_range(0, 255));
        repeat (3) @(negedge clk);

        // Reset state of every reader.
        for (int d = 0; d < 3; d++) begin
            check("rst_raddr", 32'(raddr[d]), 32'd0);
            check("rst_valid", 32'(pix_valid[d]), 32'd0);
            check("rst_last", 32'(pix_last[d]), 32'd0);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_done", 32'(done[d]), 32'd0);
            check("rst_data", 32'(pix_data[d]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed COUNT=4 line with exact cycle timing.
        ram[10] = 8'hA1; ram[11] = 8'hA2; ram[12] = 8'hA3; ram[13] = 8'hA4;
        run_line(0, 10, 4, 1'b0, 1'b1, 1'b0);
        // Address wrap from 255 to 0.
        run_line(0, 254, 4, 1'b0, 1'b1, 1'b0);
        // Random bases and random backpressure.
        repeat (3) run_line(0, int'($urandom_range(0, 255)), 4, 1'b1, 1'b0, 1'b0);

        // COUNT=8 with random backpressure, then full-rate timing.
        repeat (4) run_line(1, int'($urandom_range(0, 255)), 8, 1'b1, 1'b0, 1'b0);
        run_line(1, 252, 8, 1'b0, 1'b1, 1'b0);
        // start with base 99 while busy is ignored; the next start uses 99.
        run_line(1, 30, 8, 1'b1, 1'b0, 1'b1);
        run_line(1, 99, 8, 1'b0, 1'b1, 1'b0);

        // Reset after 3 of 8 pixels.
        start[1]     = 1'b1;
        base_addr[1] = 8'd40;
        pix_ready[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        npix = 0;
        for (int c = 1; c <= 20 && npix < 3; c++) begin
            if (pix_valid[1]) begin
                check("pre_rst_data", 32'(pix_data[1]), 32'(ram[8'(40 + npix)]));
                npix++;
            end
            @(negedge clk);
        end
        check("pre_rst_count", 32'(npix), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 32'(pix_valid[1]), 32'd0);
        check("mid_rst_busy", 32'(busy[1]), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(pix_valid[1]), 32'd0);
        end
        pix_ready[1] = 1'b0;
        run_line(1, 40, 8, 1'b0, 1'b1, 1'b0);

        // Reset wins over a simultaneous start.
        rst          = 1'b1;
        start[0]     = 1'b1;
        base_addr[0] = 8'd77;
        @(negedge clk);
        rst      = 1'b0;
        start[0] = 1'b0;
        check("rst_prio_busy", 32'(busy[0]), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_prio_quiet", 32'(pix_valid[0] | busy[0]), 32'd0);
        end

        // COUNT=1 single-pixel line, then random ones.
        ram[5] = 8'h3C;
        run_line(2, 5, 1, 1'b0, 1'b1, 1'b0);
        repeat (2) run_line(2, int'($urandom_range(0, 255)), 1, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
